debug_access_ctrl: RTL and testbench

- Sequences the datapath's coprocessor debug port (coprocessorIOAddr/Control/DataOut/DataIn) on behalf of an external debug host (UART/JTAG bridge).
- Accepts valid/ready commands: halt, resume, single-step, and GPR/CSR read or write.
- Any nonzero control word stalls the PC, so this block owns core halting.
- Sits beside datapath in the SoC top, between the host bridge and the datapath debug pins.

---
 rtl/debug_pkg.sv | 46 ++++
 rtl/debug_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_debug_access_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared types and constants for the debug access sequencer.
package debug_pkg;

    localparam int HALT_SETTLE = 2;

    // Bit positions inside the coprocessor control word.
    localparam int DBG_WE   = 0;
    localparam int DBG_RD   = 1;
    localparam int DBG_HALT = 2;
    localparam int DBG_CSR  = 3;

    typedef enum logic [2:0] {
        CMD_HALT   = 3'd0,
        CMD_RESUME = 3'd1,
        CMD_STEP   = 3'd2,
        CMD_RD_GPR = 3'd3,
        CMD_WR_GPR = 3'd4,
        CMD_RD_CSR = 3'd5,
        CMD_WR_CSR = 3'd6,
        CMD_RSVD   = 3'd7
    } dbg_cmd_t;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HALTING,
        ST_HALTED,
        ST_ACCESS,
        ST_CAPTURE,
        ST_STEP,
        ST_RESP
    } dbg_state_t;

    function automatic logic is_access(input dbg_cmd_t c);
        return (c == CMD_RD_GPR) || (c == CMD_WR_GPR) ||
               (c == CMD_RD_CSR) || (c == CMD_WR_CSR);
    endfunction

    function automatic logic is_read(input dbg_cmd_t c);
        return (c == CMD_RD_GPR) || (c == CMD_RD_CSR);
    endfunction

    function automatic logic is_csr(input dbg_cmd_t c);
        return (c == CMD_RD_CSR) || (c == CMD_WR_CSR);
    endfunction

endpackage

// File: rtl/debug_access_ctrl.sv
// Debug-host command sequencer driving the datapath coprocessor debug port.
// Owns core halting: any nonzero control word stalls the PC.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | core running, control word 0, accepts commands
// ST_HALTING | halt bit asserted, waiting for the settle counter
// ST_HALTED  | core held, accepts commands
// ST_ACCESS  | one-cycle GPR/CSR access (write strobe or read strobe)
// ST_CAPTURE | read strobe held, read data registered at end of cycle
// ST_STEP    | control word dropped for one cycle so one instruction retires
// ST_RESP    | response presented to host until resp_ready
module debug_access_ctrl #(
    parameter int N           = 64,
    parameter int HALT_SETTLE = debug_pkg::HALT_SETTLE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_cmd,
    input  logic [11:0]   req_addr,
    input  logic [N-1:0]  req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [N-1:0]  resp_rdata,
    output logic          resp_err,
    output logic          halted,
    output logic [14:0]   dbg_addr,
    output logic [4:0]    dbg_ctrl,
    output logic [N-1:0]  dbg_wdata,
    input  logic [N-1:0]  dbg_rdata
);
    import debug_pkg::*;

    localparam logic [3:0] SETTLE_LOAD = 4'(HALT_SETTLE - 1);

    dbg_state_t    state_q, state_d;
    dbg_cmd_t      cmd_q, cmd_in;
    logic [11:0]   addr_q;
    logic [N-1:0]  wdata_q;
    logic [3:0]    settle_q;
    logic          halted_q;
    logic          ready_q;
    logic [N-1:0]  rdata_q;
    logic          err_q;
    logic          accept;
    logic          err_d;
    logic [14:0]   acc_addr;

    // GPR accesses only carry a 5-bit index; upper address bits are dropped.
    assign acc_addr = is_csr(cmd_q) ? {3'b000, addr_q} : {10'd0, addr_q[4:0]};

    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign halted     = halted_q;

    // Next-state and debug-port drive, decoded from the current state.
    always_comb begin
        cmd_in    = dbg_cmd_t'(req_cmd);
        req_ready = ready_q && ((state_q == ST_RUN) || (state_q == ST_HALTED));
        accept    = req_valid && req_ready;
        err_d     = (cmd_in == CMD_RSVD) ||
                    ((state_q == ST_RUN) && ((cmd_in == CMD_STEP) || is_access(cmd_in)));
        state_d   = state_q;
        dbg_ctrl  = '0;
        dbg_addr  = '0;
        dbg_wdata = '0;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    state_d = (cmd_in == CMD_HALT) ? ST_HALTING : ST_RESP;
                end
            end
            ST_HALTING: begin
                dbg_ctrl[DBG_HALT] = 1'b1;
                if (settle_q == 4'd0) begin
                    state_d = ST_RESP;
                end
            end
            ST_HALTED: begin
                dbg_ctrl[DBG_HALT] = 1'b1;
                if (accept) begin
                    case (cmd_in)
                        CMD_STEP:                                       state_d = ST_STEP;
                        CMD_RD_GPR, CMD_WR_GPR, CMD_RD_CSR, CMD_WR_CSR: state_d = ST_ACCESS;
                        default:                                        state_d = ST_RESP;
                    endcase
                end
            end
            ST_ACCESS: begin
                dbg_ctrl[DBG_HALT] = 1'b1;
                dbg_ctrl[DBG_CSR]  = is_csr(cmd_q);
                dbg_ctrl[DBG_RD]   = is_read(cmd_q);
                dbg_ctrl[DBG_WE]   = !is_read(cmd_q);
                dbg_addr           = acc_addr;
                dbg_wdata          = is_read(cmd_q) ? '0 : wdata_q;
                state_d            = is_read(cmd_q) ? ST_CAPTURE : ST_RESP;
            end
            ST_CAPTURE: begin
                dbg_ctrl[DBG_HALT] = 1'b1;
                dbg_ctrl[DBG_CSR]  = is_csr(cmd_q);
                dbg_ctrl[DBG_RD]   = 1'b1;
                dbg_addr           = acc_addr;
                state_d            = ST_RESP;
            end
            ST_STEP: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                dbg_ctrl[DBG_HALT] = halted_q;
                if (resp_ready) begin
                    state_d = halted_q ? ST_HALTED : ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State register and command latch taken on the accept edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            ready_q <= 1'b0;
            cmd_q   <= CMD_HALT;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            if (accept) begin
                cmd_q   <= cmd_in;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Settle down-counter, halted flag and response register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle_q <= '0;
            halted_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                settle_q <= SETTLE_LOAD;
                rdata_q  <= '0;
                err_q    <= err_d;
            end else if ((state_q == ST_HALTING) && (settle_q != 4'd0)) begin
                settle_q <= settle_q - 4'd1;
            end
            if ((state_q == ST_HALTING) && (settle_q == 4'd0)) begin
                halted_q <= 1'b1;
            end
            // Resume drops halted on the edge into RESP, together with resp_valid.
            if (accept && (state_q == ST_HALTED) && (cmd_in == CMD_RESUME)) begin
                halted_q <= 1'b0;
            end
            if (state_q == ST_CAPTURE) begin
                rdata_q <= dbg_rdata;
            end
            if ((state_q == ST_RESP) && resp_ready) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_access_ctrl.sv
// Scoreboard bench for debug_access_ctrl with a behavioural core register file.
module tb_debug_access_ctrl;
    import debug_pkg::*;

    localparam int N  = 64;
    localparam int HS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_cmd = 3'd0;
    logic [11:0]   req_addr = 12'd0;
    logic [N-1:0]  req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [N-1:0]  resp_rdata;
    logic          resp_err;
    logic          halted;
    logic [14:0]   dbg_addr;
    logic [4:0]    dbg_ctrl;
    logic [N-1:0]  dbg_wdata;
    logic [N-1:0]  dbg_rdata;

    debug_access_ctrl #(.N(N), .HALT_SETTLE(HS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .halted(halted),
        .dbg_addr(dbg_addr), .dbg_ctrl(dbg_ctrl), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: register file plus CSR space behind the debug port.
    logic [N-1:0] gpr_mem [32];
    logic [N-1:0] csr_mem [4096];
    assign dbg_rdata = dbg_ctrl[1] ? (dbg_ctrl[3] ? csr_mem[dbg_addr[11:0]] : gpr_mem[dbg_addr[4:0]]) : '0;
    initial begin
        for (int i = 0; i < 32; i++) gpr_mem[i] = '0;
        for (int i = 0; i < 4096; i++) csr_mem[i] = '0;
        forever begin
            @(posedge clk);
            if (dbg_ctrl[0]) begin
                if (dbg_ctrl[3]) csr_mem[dbg_addr[11:0]] = dbg_wdata;
                else if (dbg_addr[4:0] != 5'd0) gpr_mem[dbg_addr[4:0]] = dbg_wdata;
            end
        end
    end

    // Reference model state (what the host believes the core holds).
    logic [N-1:0] gpr_ref [32];
    logic [N-1:0] csr_ref [4096];
    bit           halted_ref = 1'b0;

    typedef struct {
        logic [N-1:0] rdata;
        logic         err;
        logic         halted;
    } exp_t;
    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Host response acceptance: fixed or randomly throttled.
    bit rr_random = 1'b0;
    bit rr_val    = 1'b1;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            resp_ready = rr_random ? 1'($urandom_range(0, 1)) : rr_val;
        end
    end

    // Monitor: every response handshake is matched against the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got rdata=%0h err=%0d with no command pending", resp_rdata, resp_err);
            end else begin
                e = sb_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 64'(resp_err), 64'(e.err));
                check("resp_halted", 64'(halted), 64'(e.halted));
                check("resp_ctrl", 64'(dbg_ctrl), 64'({2'b00, e.halted, 2'b00}));
            end
        end
    end

    // Spec-level outcome of one command given the current halted belief.
    task automatic model(input logic [2:0] cmd, input logic [11:0] addr, input logic [N-1:0] wd,
                         output exp_t e, output int lat, output int we_n, output int rd_n,
                         output int low_n);
        logic [4:0] idx;
        idx = addr[4:0];
        e.rdata = '0; e.err = 1'b0; lat = 1; we_n = 0; rd_n = 0; low_n = 0;
        if (cmd == 3'd7) begin
            e.err = 1'b1;
        end else if (!halted_ref) begin
            if (cmd == CMD_HALT) begin
                lat = HS + 1;
                halted_ref = 1'b1;
            end else if (cmd != CMD_RESUME) begin
                e.err = 1'b1;
            end
        end else begin
            case (cmd)
                CMD_RESUME: halted_ref = 1'b0;
                CMD_STEP:   begin lat = 2; low_n = 1; end
                CMD_RD_GPR: begin lat = 3; rd_n = 2; e.rdata = gpr_ref[idx]; end
                CMD_WR_GPR: begin lat = 2; we_n = 1; if (idx != 5'd0) gpr_ref[idx] = wd; end
                CMD_RD_CSR: begin lat = 3; rd_n = 2; e.rdata = csr_ref[addr]; end
                CMD_WR_CSR: begin lat = 2; we_n = 1; csr_ref[addr] = wd; end
                default: ;
            endcase
        end
        e.halted = halted_ref;
    endtask

    task automatic drive_accept(input logic [2:0] cmd, input logic [11:0] addr,
                                input logic [N-1:0] wd, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL req_ready_timeout: got req_ready=0 want 1 within 100 cycles");
            return;
        end
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ok = 1'b1;
    endtask

    // Issue one command, then watch the debug port until the response appears.
    task automatic send(input logic [2:0] cmd, input logic [11:0] addr, input logic [N-1:0] wd);
        exp_t e;
        int lat, we_n, rd_n, low_n, n, cwe, crd, clow;
        bit ok, seen;
        logic rd, csr;
        logic [14:0] ea;
        logic [4:0] ectl;
        rd   = (cmd == CMD_RD_GPR) || (cmd == CMD_RD_CSR);
        csr  = (cmd == CMD_RD_CSR) || (cmd == CMD_WR_CSR);
        ea   = csr ? {3'b000, addr} : {10'd0, addr[4:0]};
        ectl = {1'b0, csr, 1'b1, rd, ~rd};
        model(cmd, addr, wd, e, lat, we_n, rd_n, low_n);
        drive_accept(cmd, addr, wd, ok);
        if (!ok) return;
        sb_q.push_back(e);
        n = 0; cwe = 0; crd = 0; clow = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (resp_valid) begin
                seen = 1'b1;
            end else begin
                if (dbg_ctrl[0]) begin
                    cwe++;
                    check("wr_data", dbg_wdata, wd);
                end
                if (dbg_ctrl[1]) crd++;
                if (dbg_ctrl[0] || dbg_ctrl[1]) begin
                    check("acc_addr", 64'(dbg_addr), 64'(ea));
                    check("acc_ctrl", 64'(dbg_ctrl), 64'(ectl));
                end
                if (!dbg_ctrl[2]) clow++;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got no resp_valid want one for cmd %0d", cmd);
            return;
        end
        check("latency", 64'(n), 64'(lat));
        check("we_cycles", 64'(cwe), 64'(we_n));
        check("rd_cycles", 64'(crd), 64'(rd_n));
        check("halt_low_cycles", 64'(clow), 64'(low_n));
        check("halted_at_resp", 64'(halted), 64'(e.halted));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || resp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || resp_valid) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got %0d pending responses want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_halted"}, 64'(halted), 64'd0);
        check({tag, "_ctrl"}, 64'(dbg_ctrl), 64'd0);
        check({tag, "_addr"}, 64'(dbg_addr), 64'd0);
        check({tag, "_wdata"}, dbg_wdata, 64'd0);
        check({tag, "_rdata"}, resp_rdata, 64'd0);
    endtask

    task automatic check_running(input string tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_halted"}, 64'(halted), 64'd0);
        check({tag, "_ctrl"}, 64'(dbg_ctrl), 64'd0);
    endtask

    task automatic ensure_halted();
        if (!halted_ref) begin
            send(CMD_HALT, 12'd0, '0);
            wait_idle();
        end
    endtask

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [2:0]   c;
        logic [11:0]  a;
        logic [N-1:0] w;
        logic [N-1:0] exp_v;
        bit           ok;
        logic [11:0]  csr_pick [4];
        csr_pick[0] = 12'h300; csr_pick[1] = 12'h341;
        csr_pick[2] = 12'h305; csr_pick[3] = 12'hfff;
        for (int i = 0; i < 32; i++) gpr_ref[i] = '0;
        for (int i = 0; i < 4096; i++) csr_ref[i] = '0;

        repeat (3) @(negedge clk);
        check_quiet("rst");
        reset = 1'b1;
        check_running("post_rst");

        // Directed sequence.
        send(CMD_HALT, 12'd0, '0);                       wait_idle();
        send(CMD_WR_GPR, 12'd5, 64'hDEAD_BEEF);          wait_idle();
        send(CMD_RD_GPR, 12'd5, '0);                     wait_idle();
        send(CMD_WR_CSR, 12'h341, 64'h80);               wait_idle();
        send(CMD_RD_CSR, 12'h341, '0);                   wait_idle();
        send(CMD_WR_GPR, 12'd0, 64'h1234);               wait_idle();
        send(CMD_RD_GPR, 12'd0, '0);                     wait_idle();
        send(CMD_WR_GPR, 12'hFE3, 64'hA5A5_0000_1111);   wait_idle();
        send(CMD_RD_GPR, 12'h003, '0);                   wait_idle();
        send(CMD_HALT, 12'd0, '0);                       wait_idle();
        send(3'd7, 12'd0, '0);                           wait_idle();
        send(CMD_STEP, 12'd0, '0);                       wait_idle();
        send(CMD_RESUME, 12'd0, '0);                     wait_idle();
        send(CMD_RD_GPR, 12'd1, '0);                     wait_idle();
        send(CMD_WR_CSR, 12'h300, 64'h5);                wait_idle();
        send(CMD_STEP, 12'd0, '0);                       wait_idle();
        send(3'd7, 12'd0, '0);                           wait_idle();
        send(CMD_RESUME, 12'd0, '0);                     wait_idle();

        // Randomized traffic with a throttling host.
        rr_random = 1'b1;
        for (int i = 0; i < 300; i++) begin
            c = 3'($urandom_range(0, 7));
            w = {$urandom, $urandom};
            if (c == CMD_RD_CSR || c == CMD_WR_CSR) a = csr_pick[$urandom_range(0, 3)];
            else a = 12'($urandom_range(0, 4095));
            send(c, a, w);
            wait_idle();
        end
        rr_random = 1'b0;
        rr_val    = 1'b1;
        @(posedge clk);

        // Reset while a CSR read is in its capture cycle.
        ensure_halted();
        send(CMD_WR_CSR, 12'h7C0, 64'hCAFE);
        wait_idle();
        drive_accept(CMD_RD_CSR, 12'h7C0, '0, ok);
        @(negedge clk);
        check("mid_access_ctrl", 64'(dbg_ctrl), 64'(5'b01110));
        @(negedge clk);
        check("mid_capture_ctrl", 64'(dbg_ctrl), 64'(5'b01110));
        check("mid_capture_addr", 64'(dbg_addr), 64'(15'h7C0));
        reset = 1'b0;
        #1;
        check_quiet("rst_capture");
        sb_q.delete();
        halted_ref = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_running("after_capture_rst");

        // Reset while a read response is held by the host.
        ensure_halted();
        exp_v = gpr_ref[5];
        rr_val = 1'b0;
        @(posedge clk);
        #2;
        send(CMD_RD_GPR, 12'd5, '0);
        repeat (3) begin
            @(negedge clk);
            check("held_resp_valid", 64'(resp_valid), 64'd1);
            check("held_resp_rdata", resp_rdata, exp_v);
        end
        reset = 1'b0;
        #1;
        check_quiet("rst_resp");
        sb_q.delete();
        halted_ref = 1'b0;
        rr_val = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        check_running("after_resp_rst");

        // Core still usable after the aborts.
        send(CMD_HALT, 12'd0, '0);     wait_idle();
        send(CMD_RESUME, 12'd0, '0);   wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
